// File: rtl/nat_reverse_lookup.sv
// -----------------------------------------------------------------------------
// nat_reverse_lookup
//   Reverse direction of the NAT connection table. Maps a connection ID back to
//   its stored 5-tuple and streams it out as four 32-bit words, or as a single
//   miss word when the entry is absent or the ID is out of range. The forward
//   tuple->ID engine mirrors every insertion here over the write port.
//
//   Optional feature: define NAT_REV_SWAP_EN to emit the tuple with source and
//   destination swapped for return traffic (W0=dip, W1=sip, W2={sport,dport}).
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_valid_i      table write strobe, one entry per cycle, any state
//   wr_id_i         entry index to write (>= DEPTH ignored)
//   wr_tuple_i      {proto,dport,sport,dip,sip}; all-zero clears the entry
//   id_valid_i      connection ID request valid
//   id_data_i       connection ID (zero-extended to 32 bits)
//   id_ready_o      high only while idle
//   tuple_valid_o   response word valid
//   tuple_data_o    response word
//   tuple_last_o    final word of the response
//   tuple_miss_o    response is a miss
//   tuple_ready_i   downstream accepts the word on valid && ready
// -----------------------------------------------------------------------------
module nat_reverse_lookup #(
  parameter int unsigned HASH_LEN = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid_i,
  input  logic [HASH_LEN:0]   wr_id_i,
  input  logic [103:0]        wr_tuple_i,
  input  logic                id_valid_i,
  input  logic [31:0]         id_data_i,
  output logic                id_ready_o,
  output logic                tuple_valid_o,
  output logic [31:0]         tuple_data_o,
  output logic                tuple_last_o,
  output logic                tuple_miss_o,
  input  logic                tuple_ready_i
);

  localparam int unsigned IDW   = HASH_LEN + 1;
  localparam int unsigned DEPTH = (1 << HASH_LEN) + 1;
  localparam int unsigned DW    = 32;
  localparam logic [IDW-1:0] DEPTH_ID = IDW'(DEPTH);

  typedef struct packed {
    logic [7:0]  proto;
    logic [15:0] dport;
    logic [15:0] sport;
    logic [31:0] dip;
    logic [31:0] sip;
  } tuple_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_W0,
    S_W1,
    S_W2,
    S_W3,
    S_MISS
  } state_t;

  // Word ordering of the serialised response
  function automatic logic [DW-1:0] word_sel(input tuple_t t, input logic [1:0] idx);
    logic [DW-1:0] w;
    w = '0;
    case (idx)
`ifdef NAT_REV_SWAP_EN
      2'd0:    w = t.dip;
      2'd1:    w = t.sip;
      2'd2:    w = {t.sport, t.dport};
`else
      2'd0:    w = t.sip;
      2'd1:    w = t.dip;
      2'd2:    w = {t.dport, t.sport};
`endif
      default: w = {24'b0, t.proto};
    endcase
    return w;
  endfunction

  // Tuple storage (not reset) and per-entry valid bits (reset)
  tuple_t           mem [DEPTH];
  logic [DEPTH-1:0] valid_bits_q, valid_bits_d;

  state_t           state_q, state_d;
  logic [IDW-1:0]   id_idx_q, id_idx_d;
  logic             id_ok_q, id_ok_d;
  tuple_t           snap_q, snap_d;
  logic             id_ready_q, id_ready_d;
  logic             tuple_valid_q, tuple_valid_d;
  logic [DW-1:0]    tuple_data_q, tuple_data_d;
  logic             tuple_last_q, tuple_last_d;
  logic             tuple_miss_q, tuple_miss_d;

  logic             wr_in_range;
  logic [IDW-1:0]   rd_idx;
  logic             fwd_hit;
  tuple_t           lk_tuple;
  logic             lk_valid;
  logic             lk_hit;

  assign wr_in_range = (wr_id_i < DEPTH_ID);

  // Table data write port
  always_ff @(posedge clk) begin
    if (wr_valid_i && wr_in_range) begin
      mem[wr_id_i] <= tuple_t'(wr_tuple_i);
    end
  end

  // Lookup read with same-cycle write forwarding
  always_comb begin
    rd_idx   = id_ok_q ? id_idx_q : '0;
    fwd_hit  = wr_valid_i && id_ok_q && (wr_id_i == id_idx_q);
    lk_tuple = fwd_hit ? tuple_t'(wr_tuple_i) : mem[rd_idx];
    lk_valid = fwd_hit ? (|wr_tuple_i) : valid_bits_q[rd_idx];
    lk_hit   = id_ok_q && lk_valid;
  end

  // Valid bit maintenance: nonzero tuple sets, all-zero tuple clears
  always_comb begin
    valid_bits_d = valid_bits_q;
    if (wr_valid_i && wr_in_range) begin
      valid_bits_d[wr_id_i] = |wr_tuple_i;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    id_idx_d      = id_idx_q;
    id_ok_d       = id_ok_q;
    snap_d        = snap_q;
    id_ready_d    = id_ready_q;
    tuple_valid_d = tuple_valid_q;
    tuple_data_d  = tuple_data_q;
    tuple_last_d  = tuple_last_q;
    tuple_miss_d  = tuple_miss_q;

    case (state_q)
      S_IDLE: begin
        if (id_valid_i && id_ready_q) begin
          id_idx_d   = id_data_i[IDW-1:0];
          id_ok_d    = (id_data_i[31:IDW] == '0) && (id_data_i[IDW-1:0] < DEPTH_ID);
          id_ready_d = 1'b0;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        snap_d        = lk_tuple;
        tuple_valid_d = 1'b1;
        if (lk_hit) begin
          state_d      = S_W0;
          tuple_data_d = word_sel(lk_tuple, 2'd0);
          tuple_last_d = 1'b0;
          tuple_miss_d = 1'b0;
        end else begin
          state_d      = S_MISS;
          tuple_data_d = '0;
          tuple_last_d = 1'b1;
          tuple_miss_d = 1'b1;
        end
      end
      S_W0: begin
        if (tuple_ready_i) begin
          state_d      = S_W1;
          tuple_data_d = word_sel(snap_q, 2'd1);
        end
      end
      S_W1: begin
        if (tuple_ready_i) begin
          state_d      = S_W2;
          tuple_data_d = word_sel(snap_q, 2'd2);
        end
      end
      S_W2: begin
        if (tuple_ready_i) begin
          state_d      = S_W3;
          tuple_data_d = word_sel(snap_q, 2'd3);
          tuple_last_d = 1'b1;
        end
      end
      S_W3, S_MISS: begin
        if (tuple_ready_i) begin
          state_d       = S_IDLE;
          id_ready_d    = 1'b1;
          tuple_valid_d = 1'b0;
          tuple_data_d  = '0;
          tuple_last_d  = 1'b0;
          tuple_miss_d  = 1'b0;
        end
      end
      default: begin
        state_d       = S_IDLE;
        id_ready_d    = 1'b1;
        tuple_valid_d = 1'b0;
        tuple_data_d  = '0;
        tuple_last_d  = 1'b0;
        tuple_miss_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      valid_bits_q  <= '0;
      id_idx_q      <= '0;
      id_ok_q       <= 1'b0;
      snap_q        <= '0;
      id_ready_q    <= 1'b1;
      tuple_valid_q <= 1'b0;
      tuple_data_q  <= '0;
      tuple_last_q  <= 1'b0;
      tuple_miss_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      valid_bits_q  <= valid_bits_d;
      id_idx_q      <= id_idx_d;
      id_ok_q       <= id_ok_d;
      snap_q        <= snap_d;
      id_ready_q    <= id_ready_d;
      tuple_valid_q <= tuple_valid_d;
      tuple_data_q  <= tuple_data_d;
      tuple_last_q  <= tuple_last_d;
      tuple_miss_q  <= tuple_miss_d;
    end
  end

  assign id_ready_o    = id_ready_q;
  assign tuple_valid_o = tuple_valid_q;
  assign tuple_data_o  = tuple_data_q;
  assign tuple_last_o  = tuple_last_q;
  assign tuple_miss_o  = tuple_miss_q;

endmodule

// File: tb/tb_nat_reverse_lookup.sv
// -----------------------------------------------------------------------------
// tb_nat_reverse_lookup
//   Self-checking bench for nat_reverse_lookup. A behavioural table model
//   (array of tuples + valid flags) produces the expected word stream for each
//   request; stimulus mixes directed scenarios with randomized writes, IDs and
//   downstream back-pressure.
// -----------------------------------------------------------------------------
module tb_nat_reverse_lookup;

  localparam int unsigned HASH_LEN = 10;
  localparam int unsigned DEPTH    = (1 << HASH_LEN) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid_i;
  logic [10:0]   wr_id_i;
  logic [103:0]  wr_tuple_i;
  logic          id_valid_i;
  logic [31:0]   id_data_i;
  logic          id_ready_o;
  logic          tuple_valid_o;
  logic [31:0]   tuple_data_o;
  logic          tuple_last_o;
  logic          tuple_miss_o;
  logic          tuple_ready_i;

  int total = 0;
  int bad   = 0;

  logic [103:0]  m_tab [DEPTH];
  bit            m_val [DEPTH];
  logic [33:0]   exp_q [$];    // {miss, last, data}

  localparam logic [103:0] T5 = {8'h06, 16'h0050, 16'h1F90, 32'h0A000002, 32'h0A000001};

  nat_reverse_lookup #(.HASH_LEN(HASH_LEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid_i    (wr_valid_i),
    .wr_id_i       (wr_id_i),
    .wr_tuple_i    (wr_tuple_i),
    .id_valid_i    (id_valid_i),
    .id_data_i     (id_data_i),
    .id_ready_o    (id_ready_o),
    .tuple_valid_o (tuple_valid_o),
    .tuple_data_o  (tuple_data_o),
    .tuple_last_o  (tuple_last_o),
    .tuple_miss_o  (tuple_miss_o),
    .tuple_ready_i (tuple_ready_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference word k of a stored tuple, from the field layout
  function automatic logic [31:0] mword(input logic [103:0] t, input int k);
    logic [7:0]  proto;
    logic [15:0] dport;
    logic [15:0] sport;
    logic [31:0] dip;
    logic [31:0] sip;
    proto = t[103:96];
    dport = t[95:80];
    sport = t[79:64];
    dip   = t[63:32];
    sip   = t[31:0];
`ifdef NAT_REV_SWAP_EN
    if (k == 0) return dip;
    if (k == 1) return sip;
    if (k == 2) return {sport, dport};
`else
    if (k == 0) return sip;
    if (k == 1) return dip;
    if (k == 2) return {dport, sport};
`endif
    return {24'h0, proto};
  endfunction

  function automatic logic [103:0] rand_tuple();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[96] = 1'b1;  // guarantee nonzero
    return r[103:0];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < int'(DEPTH); i++) m_val[i] = 1'b0;
  endfunction

  function automatic void build_exp(input logic [31:0] id);
    logic [10:0] idx;
    idx = id[10:0];
    exp_q.delete();
    if (id < 32'(DEPTH) && m_val[idx]) begin
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, (k == 3), mword(m_tab[idx], k)});
    end else begin
      exp_q.push_back({1'b1, 1'b1, 32'h0});
    end
  endfunction

  task automatic wr(input int unsigned id, input logic [103:0] t);
    wr_valid_i = 1'b1;
    wr_id_i    = 11'(id);
    wr_tuple_i = t;
    tick();
    wr_valid_i = 1'b0;
    if (id < DEPTH) begin
      m_tab[id] = t;
      m_val[id] = (t != '0);
    end
  endtask

  // Handshake one request and check the two-cycle latency
  task automatic send_req(input logic [31:0] id);
    int g;
    g = 0;
    while (id_ready_o !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    total++;
    if (id_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL req_ready: id_ready_o=%b required 1", id_ready_o);
    end
    id_valid_i = 1'b1;
    id_data_i  = id;
    tick();
    id_valid_i = 1'b0;
    id_data_i  = $urandom;
    total++;
    if (tuple_valid_o !== 1'b0 || id_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL lat_n1: valid=%b ready=%b required 0 0", tuple_valid_o, id_ready_o);
    end
    tick();
    total++;
    if (tuple_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL lat_n2: valid=%b required 1", tuple_valid_o);
    end
  endtask

  // Drain the expected queue; rmode 0=always ready, 1=1,0,0 pattern, 2=random
  task automatic collect(input int rmode, output int hs);
    int          cyc;
    logic        pstall;
    logic [33:0] pv;
    logic [33:0] e;
    logic        rdy;
    cyc    = 0;
    hs     = 0;
    pstall = 1'b0;
    pv     = '0;
    while (exp_q.size() > 0 && cyc < 200) begin
      if (rmode == 0)      rdy = 1'b1;
      else if (rmode == 1) rdy = ((cyc % 3) == 0);
      else                 rdy = 1'($urandom_range(0, 1));
      tuple_ready_i = rdy;
      if (pstall) begin
        total++;
        if (tuple_valid_o !== 1'b1 || {tuple_miss_o, tuple_last_o, tuple_data_o} !== pv) begin
          bad++;
          $display("FAIL stall_hold: valid=%b got=%h required=%h", tuple_valid_o,
                   {tuple_miss_o, tuple_last_o, tuple_data_o}, pv);
        end
      end
      total++;
      if (id_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL busy_ready: id_ready_o=%b required 0", id_ready_o);
      end
      if (tuple_valid_o === 1'b1 && rdy) begin
        e = exp_q.pop_front();
        hs++;
        total++;
        if ({tuple_miss_o, tuple_last_o, tuple_data_o} !== e) begin
          bad++;
          $display("FAIL word%0d: {miss,last,data}=%h required %h", hs - 1,
                   {tuple_miss_o, tuple_last_o, tuple_data_o}, e);
        end
      end
      pstall = (tuple_valid_o === 1'b1) && !rdy;
      pv     = {tuple_miss_o, tuple_last_o, tuple_data_o};
      tick();
      cyc++;
    end
    tuple_ready_i = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL resp_timeout: %0d words outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if (tuple_valid_o !== 1'b0 || id_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL end_idle: valid=%b ready=%b required 0 1", tuple_valid_o, id_ready_o);
    end
  endtask

  task automatic request(input logic [31:0] id, input int rmode, output int hs);
    build_exp(id);
    send_req(id);
    collect(rmode, hs);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_valid_i = 1'b0; wr_id_i = '0; wr_tuple_i = '0;
    id_valid_i = 1'b0; id_data_i = '0; tuple_ready_i = 1'b0;
    model_clear();
    repeat (3) tick();
    total++;
    if (tuple_valid_o !== 1'b0 || tuple_last_o !== 1'b0 || tuple_miss_o !== 1'b0 || tuple_data_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_out: v=%b l=%b m=%b d=%h required 0", tuple_valid_o, tuple_last_o, tuple_miss_o, tuple_data_o);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (id_ready_o !== 1'b1 || tuple_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: ready=%b valid=%b required 1 0", id_ready_o, tuple_valid_o);
    end
  endtask

  task automatic test_miss_unwritten();
    int hs;
    request(32'd7, 0, hs);
  endtask

  task automatic test_basic_hit();
    int hs;
    wr(5, T5);
    exp_q.delete();
`ifdef NAT_REV_SWAP_EN
    exp_q.push_back({2'b00, 32'h0A000002});
    exp_q.push_back({2'b00, 32'h0A000001});
    exp_q.push_back({2'b00, 32'h1F900050});
`else
    exp_q.push_back({2'b00, 32'h0A000001});
    exp_q.push_back({2'b00, 32'h0A000002});
    exp_q.push_back({2'b00, 32'h00501F90});
`endif
    exp_q.push_back({2'b01, 32'h00000006});
    send_req(32'd5);
    collect(0, hs);
  endtask

  task automatic test_out_of_range();
    int hs;
    request(32'h0000_0401, 0, hs);
    request(32'h8000_0000, 2, hs);
    wr(1024, rand_tuple());            // last valid index
    request(32'h0000_0400, 0, hs);
    wr(1025, rand_tuple());            // beyond depth, ignored
    request(32'h0000_0401, 0, hs);
    request(32'h0000_0805, 0, hs);     // id bits above index width
  endtask

  task automatic test_stall();
    int hs;
    request(32'd5, 1, hs);
    total++;
    if (hs != 4) begin
      bad++;
      $display("FAIL stall_count: handshakes=%0d required 4", hs);
    end
  endtask

  task automatic test_forwarding();
    logic [103:0] ta;
    logic [103:0] tb;
    int hs;
    ta = rand_tuple();
    tb = rand_tuple();
    wr(9, '0);
    id_valid_i = 1'b1;
    id_data_i  = 32'd9;
    tick();
    id_valid_i = 1'b0;
    // lookup cycle: same-cycle write must be forwarded
    wr_valid_i = 1'b1; wr_id_i = 11'd9; wr_tuple_i = ta;
    tick();
    wr_valid_i = 1'b0;
    m_tab[9] = ta; m_val[9] = 1'b1;
    tuple_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        wr_valid_i = 1'b1; wr_id_i = 11'd9; wr_tuple_i = tb;
      end
      total++;
      if (tuple_valid_o !== 1'b1 || {tuple_miss_o, tuple_last_o, tuple_data_o} !== {1'b0, (k == 3), mword(ta, k)}) begin
        bad++;
        $display("FAIL fwd_word%0d: v=%b got=%h required %h", k, tuple_valid_o,
                 {tuple_miss_o, tuple_last_o, tuple_data_o}, {1'b0, (k == 3), mword(ta, k)});
      end
      tick();
      wr_valid_i = 1'b0;
    end
    tuple_ready_i = 1'b0;
    m_tab[9] = tb;
    total++;
    if (tuple_valid_o !== 1'b0 || id_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL fwd_idle: valid=%b ready=%b required 0 1", tuple_valid_o, id_ready_o);
    end
    request(32'd9, 0, hs);             // rewritten tuple
    wr(9, '0);
    request(32'd9, 2, hs);             // cleared -> miss
  endtask

  task automatic test_random();
    int unsigned id;
    logic [31:0] rid;
    int hs;
    int sel;
    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
        id = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 15);
        wr(id, ($urandom_range(0, 4) == 0) ? 104'h0 : rand_tuple());
      end
      sel = int'($urandom_range(0, 5));
      if (sel == 0)      rid = $urandom;
      else if (sel == 1) rid = 32'($urandom_range(DEPTH, 2047));
      else               rid = 32'($urandom_range(0, 15));
      request(rid, int'($urandom_range(0, 2)), hs);
    end
  endtask

  task automatic test_reset_mid_burst();
    int hs;
    wr(5, T5);
    send_req(32'd5);
    tuple_ready_i = 1'b1;
    tick();
    tick();
    total++;
    if (tuple_data_o !== mword(T5, 2) || tuple_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_w2: v=%b d=%h required 1 %h", tuple_valid_o, tuple_data_o, mword(T5, 2));
    end
    tuple_ready_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (tuple_valid_o !== 1'b0 || tuple_last_o !== 1'b0 || tuple_miss_o !== 1'b0 || tuple_data_o !== 32'h0) begin
      bad++;
      $display("FAIL rst_async: v=%b l=%b m=%b d=%h required 0", tuple_valid_o, tuple_last_o, tuple_miss_o, tuple_data_o);
    end
    model_clear();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (id_ready_o !== 1'b1 || tuple_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_release: ready=%b valid=%b required 1 0", id_ready_o, tuple_valid_o);
    end
    request(32'd5, 0, hs);
  endtask

  initial begin
    test_reset();
    test_miss_unwritten();
    test_basic_hit();
    test_out_of_range();
    test_stall();
    test_forwarding();
    test_random();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
